cpu_core_hs: RTL and testbench

Parametrised successor of the 4-bit single-cycle CPU. Data and address widths are generic. Instruction fetch uses a variable-latency req/ack handshake, so slow ROM/RAM can back it. Adds a zero flag, SUB, JZ, HALT/resume and an output-strobe. Sits between the instruction memory and the LED/switch I/O, driven by the common ctrl clock/reset.

---
 rtl/cpu_core_hs.sv | 195 +++++++++++++++++++
 tb/tb_cpu_core_hs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_hs.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core_hs
// Brief    : Parametrised accumulator CPU with req/ack instruction fetch,
//            carry/zero flags, HALT/resume and an output strobe.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_core_hs #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW+3:0] mem_data,
    input  logic [DW-1:0] switch,
    output logic [DW-1:0] led,
    output logic          out_valid,
    input  logic          resume,
    output logic          halted
);

    localparam int IW = 4 + DW;

    localparam logic [3:0] c_OP_ADD_A  = 4'b0000;
    localparam logic [3:0] c_OP_MOV_AB = 4'b0001;
    localparam logic [3:0] c_OP_IN_A   = 4'b0010;
    localparam logic [3:0] c_OP_MOV_AI = 4'b0011;
    localparam logic [3:0] c_OP_MOV_BA = 4'b0100;
    localparam logic [3:0] c_OP_ADD_B  = 4'b0101;
    localparam logic [3:0] c_OP_IN_B   = 4'b0110;
    localparam logic [3:0] c_OP_MOV_BI = 4'b0111;
    localparam logic [3:0] c_OP_SUB_A  = 4'b1000;
    localparam logic [3:0] c_OP_OUT_B  = 4'b1001;
    localparam logic [3:0] c_OP_JZ     = 4'b1010;
    localparam logic [3:0] c_OP_OUT_I  = 4'b1011;
    localparam logic [3:0] c_OP_HALT   = 4'b1100;
    localparam logic [3:0] c_OP_JNC    = 4'b1110;
    localparam logic [3:0] c_OP_JMP    = 4'b1111;

    localparam logic [AW-1:0] c_IP_INC = AW'(1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_started;
    logic [AW-1:0]   r_ip, w_ip_nxt;
    logic [DW-1:0]   r_a, w_a_nxt;
    logic [DW-1:0]   r_b, w_b_nxt;
    logic            r_c, w_c_nxt;
    logic            r_z, w_z_nxt;
    logic [DW-1:0]   r_led, w_led_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [IW-1:0]   r_instr, w_instr_nxt;

    logic            w_req;
    logic [3:0]      w_op;
    logic [DW-1:0]   w_imm;
    logic [AW-1:0]   w_target;
    logic [DW:0]     w_sum_a;
    logic [DW:0]     w_sum_b;
    logic [DW:0]     w_diff_a;

    assign w_op  = r_instr[IW-1:DW];
    assign w_imm = r_instr[DW-1:0];

    // Jump target: immediate truncated or zero-extended to the address width
    generate
        if (AW > DW) begin : g_target_zext
            assign w_target = {{(AW-DW){1'b0}}, w_imm};
        end else begin : g_target_trunc
            assign w_target = w_imm[AW-1:0];
        end
    endgenerate

    assign w_sum_a  = {1'b0, r_a} + {1'b0, w_imm};
    assign w_sum_b  = {1'b0, r_b} + {1'b0, w_imm};
    assign w_diff_a = {1'b0, r_a} - {1'b0, w_imm};

    // r_started keeps the request low during the first cycle after reset release
    assign w_req     = r_started && (r_state == S_FETCH);
    assign mem_req   = w_req;
    assign mem_addr  = r_ip;
    assign led       = r_led;
    assign out_valid = r_out_valid;
    assign halted    = (r_state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_started   <= 1'b0;
            r_ip        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_led       <= '0;
            r_out_valid <= 1'b0;
            r_instr     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_started   <= 1'b1;
            r_ip        <= w_ip_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_c         <= w_c_nxt;
            r_z         <= w_z_nxt;
            r_led       <= w_led_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_instr     <= w_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ip_nxt        = r_ip;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_c_nxt         = r_c;
        w_z_nxt         = r_z;
        w_led_nxt       = r_led;
        w_out_valid_nxt = 1'b0;
        w_instr_nxt     = r_instr;

        case (r_state)
            S_FETCH: begin
                if (w_req && mem_ack) begin
                    w_instr_nxt = mem_data;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_ip_nxt    = r_ip + c_IP_INC;
                // Carry is cleared by everything except ADD/SUB; Z only moves on ADD/SUB
                w_c_nxt     = 1'b0;
                case (w_op)
                    c_OP_ADD_A: begin
                        {w_c_nxt, w_a_nxt} = w_sum_a;
                        w_z_nxt = (w_sum_a[DW-1:0] == '0);
                    end
                    c_OP_ADD_B: begin
                        {w_c_nxt, w_b_nxt} = w_sum_b;
                        w_z_nxt = (w_sum_b[DW-1:0] == '0);
                    end
                    c_OP_SUB_A: begin
                        {w_c_nxt, w_a_nxt} = w_diff_a;
                        w_z_nxt = (w_diff_a[DW-1:0] == '0);
                    end
                    c_OP_MOV_AI: w_a_nxt = w_imm;
                    c_OP_MOV_BI: w_b_nxt = w_imm;
                    c_OP_MOV_AB: w_a_nxt = r_b;
                    c_OP_MOV_BA: w_b_nxt = r_a;
                    c_OP_IN_A:   w_a_nxt = switch;
                    c_OP_IN_B:   w_b_nxt = switch;
                    c_OP_OUT_B: begin
                        w_led_nxt       = r_b;
                        w_out_valid_nxt = 1'b1;
                    end
                    c_OP_OUT_I: begin
                        w_led_nxt       = w_imm;
                        w_out_valid_nxt = 1'b1;
                    end
                    c_OP_JMP: w_ip_nxt = w_target;
                    c_OP_JNC: begin
                        if (!r_c) begin
                            w_ip_nxt = w_target;
                        end
                    end
                    c_OP_JZ: begin
                        if (r_z) begin
                            w_ip_nxt = w_target;
                        end
                    end
                    c_OP_HALT: w_state_nxt = S_HALT;
                    default: ;
                endcase
            end
            S_HALT: begin
                if (resume) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_core_hs
// Brief    : Directed program runs for cpu_core_hs (zero-wait and wait-state
//            memory, HALT/resume, ip wrap at AW=4, reset during fetch).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_core_hs;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [11:0] mem_data;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic        out_valid;
    logic        resume;
    logic        halted;

    logic        mem_req4;
    logic [3:0]  mem_addr4;
    logic        mem_ack4;
    logic [7:0]  mem_data4;
    logic [3:0]  switch4;
    logic [3:0]  led4;
    logic        out_valid4;
    logic        resume4;
    logic        halted4;

    int checks = 0;
    int errors = 0;

    logic [11:0] rom [256];
    int          lat_mode;
    int          cur_lat;
    int          cnt;
    logic [7:0]  req_addr;
    logic [7:0]  outs [$];
    int          ov_cycles;
    logic        ov_prev;
    logic [7:0]  exp_outs [6];

    cpu_core_hs #(.DW(8), .AW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .switch(switch), .led(led),
        .out_valid(out_valid), .resume(resume), .halted(halted)
    );

    cpu_core_hs #(.DW(4), .AW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req4), .mem_addr(mem_addr4),
        .mem_ack(mem_ack4), .mem_data(mem_data4), .switch(switch4), .led(led4),
        .out_valid(out_valid4), .resume(resume4), .halted(halted4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction memory model with selectable latency: 0 = zero-wait, 1 = random, 2 = never ack
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        cnt      = 0;
        req_addr = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst_n && mem_req) begin
                if (cnt == 0) req_addr = mem_addr;
                else check("addr_stable", mem_addr, req_addr);
                if (lat_mode != 2 && cnt >= cur_lat) begin
                    mem_ack  = 1'b1;
                    mem_data = rom[mem_addr];
                    cnt      = 0;
                    cur_lat  = (lat_mode == 1) ? int'($urandom_range(0, 5)) : 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        mem_ack4  = 1'b0;
        mem_data4 = 8'hD0;
        forever begin
            @(negedge clk);
            mem_ack4 = mem_req4 & rst_n;
        end
    end

    initial begin
        ov_prev   = 1'b0;
        ov_cycles = 0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ov_cycles++;
                if (!ov_prev) outs.push_back(led);
            end
            ov_prev = (out_valid === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (chk) begin
            check("rst_mem_req", mem_req, 1'b0);
            check("rst_mem_addr", mem_addr, 8'h00);
            check("rst_led", led, 8'h00);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_halted", halted, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic run_prog(input int mode, input bit timing_chk);
        lat_mode = mode;
        cur_lat  = (mode == 1) ? 3 : 0;
        switch   = 8'hA5;
        resume   = 1'b0;
        do_reset(1'b0);
        outs.delete();
        ov_cycles = 0;
        if (timing_chk) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("fetch_req", mem_req, 1'b1);
                check("fetch_addr", mem_addr, k);
                @(negedge clk);
                check("exec_req", mem_req, 1'b0);
            end
        end
        wait_halt(1500);
        check("halt_ip", mem_addr, 8'h21);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5)  switch = 8'h3C;
            if (i == 10) switch = 8'h01;
            check("halt_hold", {mem_req, halted}, 2'b01);
        end
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume_req", mem_req, 1'b1);
        check("resume_addr", mem_addr, 8'h21);
        wait_halt(1500);
        check("wrap_ip", mem_addr, 8'h00);
        check("out_count", outs.size(), 6);
        check("out_valid_cycles", ov_cycles, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < outs.size()) check("out_value", outs[i], exp_outs[i]);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        switch   = 8'hA5;
        resume   = 1'b0;
        switch4  = 4'h0;
        resume4  = 1'b0;
        lat_mode = 0;
        cur_lat  = 0;

        for (int i = 0; i < 256; i++) rom[i] = 12'hD00;
        rom[8'h00] = 12'h303;  // MOV A,3
        rom[8'h01] = 12'h005;  // ADD A,5      A=8 C=0
        rom[8'h02] = 12'hB2A;  // OUT 0x2A
        rom[8'h03] = 12'h400;  // MOV B,A
        rom[8'h04] = 12'h900;  // OUT B        -> 08
        rom[8'h05] = 12'h3FF;  // MOV A,FF
        rom[8'h06] = 12'h001;  // ADD A,1      A=0 C=1 Z=1
        rom[8'h07] = 12'hE10;  // JNC 10       not taken
        rom[8'h08] = 12'h400;  // MOV B,A
        rom[8'h09] = 12'h900;  // OUT B        -> 00
        rom[8'h0A] = 12'h700;  // MOV B,0      C=0
        rom[8'h0B] = 12'hE10;  // JNC 10       taken
        rom[8'h0C] = 12'hB99;
        rom[8'h10] = 12'h302;  // MOV A,2
        rom[8'h11] = 12'h805;  // SUB A,5      A=FD C=1 Z=0
        rom[8'h12] = 12'hE19;  // JNC 19       not taken
        rom[8'h13] = 12'hA19;  // JZ 19        not taken
        rom[8'h14] = 12'h400;  // MOV B,A
        rom[8'h15] = 12'h900;  // OUT B        -> FD
        rom[8'h16] = 12'h305;  // MOV A,5
        rom[8'h17] = 12'h805;  // SUB A,5      A=0 C=0 Z=1
        rom[8'h18] = 12'hA20;  // JZ 20        taken
        rom[8'h19] = 12'hB99;
        rom[8'h20] = 12'hC00;  // HALT
        rom[8'h21] = 12'h600;  // IN B
        rom[8'h22] = 12'h900;  // OUT B        -> switch
        rom[8'h23] = 12'h5FF;  // ADD B,FF     B=0 C=1 Z=1
        rom[8'h24] = 12'hE30;  // JNC 30       not taken
        rom[8'h25] = 12'h100;  // MOV A,B      C=0, Z held
        rom[8'h26] = 12'hA28;  // JZ 28        taken
        rom[8'h27] = 12'hB77;
        rom[8'h28] = 12'hB55;  // OUT 0x55
        rom[8'h29] = 12'hFFE;  // JMP FE
        rom[8'h30] = 12'hB66;
        rom[8'hFF] = 12'hC00;  // HALT, ip wraps to 0

        exp_outs[0] = 8'h2A;
        exp_outs[1] = 8'h08;
        exp_outs[2] = 8'h00;
        exp_outs[3] = 8'hFD;
        exp_outs[4] = 8'h01;
        exp_outs[5] = 8'h55;

        // Reset values, then ip wrap on the AW=4 instance running only NOPs
        do_reset(1'b1);
        @(negedge clk);
        check("first_req", mem_req, 1'b1);
        begin
            int n = 0;
            while (!(mem_req4 === 1'b1 && mem_addr4 === 4'hF) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("aw4_reach_15", mem_addr4, 4'hF);
            @(negedge clk);
            @(negedge clk);
            check("aw4_wrap_req", mem_req4, 1'b1);
            check("aw4_wrap_addr", mem_addr4, 4'h0);
            check("aw4_led", led4, 4'h0);
        end

        run_prog(0, 1'b1);
        run_prog(1, 1'b0);

        // Reset while a fetch is outstanding
        lat_mode = 2;
        check("pre_rst_led", led, 8'h55);
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("pend_req", mem_req, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_addr", mem_addr, 8'h00);
        check("midrst_led", led, 8'h00);
        check("midrst_halted", halted, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        lat_mode = 0;
        cur_lat  = 0;
        @(negedge clk);
        check("post_rst_req", mem_req, 1'b1);
        check("post_rst_addr", mem_addr, 8'h00);
        check("post_rst_led", led, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
